// File: rtl/seg_display_engine.sv
// Multi-channel binary to 7-segment display engine.
// One shared double-dabble datapath serves all channels in round-robin order.
module seg_display_engine #(
  parameter int WIDTH    = 6,
  parameter int DIGITS   = 2,
  parameter int CHANNELS = 2,
  parameter int BLANK_LZ = 0,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         freeze,
  input  logic [CHANNELS*WIDTH-1:0]    in,
  output logic [CHANNELS*DIGITS*7-1:0] hex,
  output logic [CW-1:0]                chan,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW   = DIGITS * 7;

  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [6:0]    SEG_DASH  = 7'h3F;
  localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] LAST_SH = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  state_t                      state_q;
  logic [WIDTH-1:0]            bin_q, bin_d;
  logic [BW-1:0]               bcd_q, bcd_d;
  logic [BW-1:0]               adj;
  logic                        ovf_q, ovf_d;
  logic [CNTW-1:0]             cnt_q;
  logic [CW-1:0]               chan_q;
  logic [CHANNELS*SW-1:0]      hex_q;
  logic                        fdone_q;
  logic [SW-1:0]               enc_d;
  logic [3:0]                  nib;
  logic                        lead;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // One shift/add-3 step; a carry out of the top nibble means the value
  // does not fit in DIGITS decimal digits.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    ovf_d = ovf_q | adj[BW-1];
    bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
    bin_d = bin_q << 1;
  end

  always_comb begin
    enc_d = '0;
    lead  = 1'b1;
    nib   = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = bcd_q[d*4 +: 4];
      if (ovf_q) begin
        enc_d[d*7 +: 7] = SEG_DASH;
      end else if (BLANK_LZ != 0 && lead && d != 0 && nib == 4'd0) begin
        enc_d[d*7 +: 7] = SEG_BLANK;
      end else begin
        enc_d[d*7 +: 7] = seg7(nib);
        lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      chan_q  <= '0;
      hex_q   <= {(CHANNELS*DIGITS){SEG_BLANK}};
      fdone_q <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!freeze) state_q <= LOAD;
        end
        LOAD: begin
          bin_q   <= in[chan_q*WIDTH +: WIDTH];
          bcd_q   <= '0;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_SH) state_q <= COMMIT;
        end
        COMMIT: begin
          hex_q[chan_q*SW +: SW] <= enc_d;
          fdone_q <= (chan_q == LAST_CH);
          chan_q  <= (chan_q == LAST_CH) ? '0 : chan_q + 1'b1;
          state_q <= freeze ? IDLE : LOAD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hex        = hex_q;
  assign chan       = chan_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_display_engine.sv
// Directed bench for seg_display_engine.
// Four instances cover the default build, overflow, blanking and 3-channel framing.
module tb_seg_display_engine;

  logic clk = 1'b0;
  logic rst_n;
  logic frz_a;
  logic frz_0 = 1'b0;

  logic [11:0] in_a;
  logic [27:0] hex_a;
  logic [0:0]  ch_a;
  logic        busy_a, fd_a;

  logic [13:0] in_b;
  logic [27:0] hex_b;
  logic [0:0]  ch_b;
  logic        busy_b, fd_b;

  logic [6:0]  in_c;
  logic [20:0] hex_c;
  logic [0:0]  ch_c;
  logic        busy_c, fd_c;

  logic [11:0] in_d;
  logic [20:0] hex_d;
  logic [1:0]  ch_d;
  logic        busy_d, fd_d;

  int n_chk  = 0;
  int n_fail = 0;
  int ec     = 0;
  int bad;
  int gap;

  always #5 clk = ~clk;

  seg_display_engine #(
    .WIDTH(6), .DIGITS(2), .CHANNELS(2), .BLANK_LZ(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .freeze(frz_a), .in(in_a),
    .hex(hex_a), .chan(ch_a), .busy(busy_a), .frame_done(fd_a)
  );

  seg_display_engine #(
    .WIDTH(7), .DIGITS(2), .CHANNELS(2), .BLANK_LZ(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .freeze(frz_0), .in(in_b),
    .hex(hex_b), .chan(ch_b), .busy(busy_b), .frame_done(fd_b)
  );

  seg_display_engine #(
    .WIDTH(7), .DIGITS(3), .CHANNELS(1), .BLANK_LZ(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .freeze(frz_0), .in(in_c),
    .hex(hex_c), .chan(ch_c), .busy(busy_c), .frame_done(fd_c)
  );

  seg_display_engine #(
    .WIDTH(4), .DIGITS(1), .CHANNELS(3), .BLANK_LZ(0)
  ) u_d (
    .clk(clk), .rst_n(rst_n), .freeze(frz_0), .in(in_d),
    .hex(hex_d), .chan(ch_d), .busy(busy_d), .frame_done(fd_d)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    ec += n;
  endtask

  task automatic upto(input int k);
    adv(k - ec);
  endtask

  task automatic wait_fd_d(output int n);
    n = 0;
    do begin
      adv(1);
      n++;
    end while (!fd_d && n < 60);
  endtask

  initial begin
    rst_n = 1'b0;
    frz_a = 1'b0;
    in_a  = {6'd7, 6'd45};
    in_b  = '0;
    in_c  = '0;
    in_d  = '0;
    adv(2);
    check("rst_hex_a", hex_a, 28'hFFFFFFF);
    check("rst_hex_d", hex_d, 21'h1FFFFF);
    check("rst_chan", ch_a, 1'b0);
    check("rst_fd", fd_a, 1'b0);

    rst_n = 1'b1;
    ec = 0;
    upto(1);
    check("busy_after_rel", busy_a, 1'b1);
    upto(7);
    check("t1_ch0_pre", hex_a[13:0], {7'h7F, 7'h7F});
    upto(8);
    check("t1_ch0_45", hex_a[13:0], {7'h19, 7'h12});
    check("t1_ch1_blank", hex_a[27:14], {7'h7F, 7'h7F});
    check("t1_chan1", ch_a, 1'b1);
    check("t1_fd_low", fd_a, 1'b0);
    upto(16);
    check("t1_ch1_07", hex_a[27:14], {7'h40, 7'h78});
    check("t1_fd_high", fd_a, 1'b1);
    check("t1_chan_wrap", ch_a, 1'b0);
    in_a[5:0] = 6'd12;
    upto(17);
    check("t1_fd_pulse", fd_a, 1'b0);

    upto(19);
    frz_a = 1'b1;
    upto(24);
    check("t4_ch0_12", hex_a[13:0], {7'h79, 7'h24});
    check("t4_busy0", busy_a, 1'b0);
    check("t4_chan1", ch_a, 1'b1);
    check("t4_fd_ch0", fd_a, 1'b0);
    in_a = {6'd63, 6'd0};
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      adv(1);
      if (hex_a !== {7'h40, 7'h78, 7'h79, 7'h24} || busy_a !== 1'b0)
        bad++;
    end
    check("t4_hold50", bad, 0);
    frz_a = 1'b0;
    in_a[5:0] = 6'd21;
    upto(75);
    check("t4_busy1", busy_a, 1'b1);
    upto(82);
    check("t4_ch1_pre", hex_a[27:14], {7'h40, 7'h78});
    upto(83);
    check("t4_ch1_63", hex_a[27:14], {7'h02, 7'h30});
    check("t4_fd", fd_a, 1'b1);
    check("t4_chan0", ch_a, 1'b0);
    upto(91);
    check("t4_ch0_21", hex_a[13:0], {7'h24, 7'h79});

    upto(94);
    rst_n = 1'b0;
    upto(95);
    check("t5_hex", hex_a, 28'hFFFFFFF);
    check("t5_chan", ch_a, 1'b0);
    check("t5_fd", fd_a, 1'b0);
    rst_n = 1'b1;
    in_a[5:0] = 6'd58;
    ec = 0;
    upto(7);
    check("t5_ch0_pre", hex_a[13:0], {7'h7F, 7'h7F});
    upto(8);
    check("t5_ch0_58", hex_a[13:0], {7'h12, 7'h00});
    check("t5_chan1", ch_a, 1'b1);

    in_b = {7'd100, 7'd99};
    adv(40);
    check("t2_99", hex_b[13:0], {7'h10, 7'h10});
    check("t2_100", hex_b[27:14], {7'h3F, 7'h3F});
    in_b = {7'd5, 7'd127};
    adv(40);
    check("t2_127", hex_b[13:0], {7'h3F, 7'h3F});
    check("t2_noleak", hex_b[27:14], {7'h40, 7'h12});

    in_c = 7'd7;
    adv(20);
    check("t3_7", hex_c, {7'h7F, 7'h7F, 7'h78});
    in_c = 7'd0;
    adv(20);
    check("t3_0", hex_c, {7'h7F, 7'h7F, 7'h40});
    in_c = 7'd105;
    adv(20);
    check("t3_105", hex_c, {7'h79, 7'h40, 7'h12});
    in_c = 7'd10;
    adv(20);
    check("t3_10", hex_c, {7'h7F, 7'h79, 7'h40});

    in_d = {4'd0, 4'd9, 4'd12};
    adv(40);
    check("t6_hex", hex_d, {7'h40, 7'h10, 7'h3F});
    wait_fd_d(gap);
    check("t6_fd_seen", fd_d, 1'b1);
    wait_fd_d(gap);
    check("t6_period1", gap, 18);
    wait_fd_d(gap);
    check("t6_period2", gap, 18);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
